multicycle_control: RTL

//  Moore FSM sequencing the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut regs).

---
 rtl/multicycle_control.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath (R-type, j, beq, bne, addi, andi, lw, sw).
// Optional build macro MEM_READY_EN adds the memReady handshake that stretches memory states.
module multicycle_control #(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
`ifdef MEM_READY_EN
  input  logic               memReady,
`endif
  output logic               pcWrite,
  output logic               pcWriteBeq,
  output logic               pcWriteBne,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instrDone,
  output logic               illegalOp,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t stateReg;
  state_t stateNext;
  logic   memReadyInt;

`ifdef MEM_READY_EN
  assign memReadyInt = memReady;
`else
  assign memReadyInt = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    pcWrite    = 1'b0;
    pcWriteBeq = 1'b0;
    pcWriteBne = 1'b0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    memtoReg   = 1'b0;
    regDst     = 1'b0;
    regWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    instrDone  = 1'b0;
    illegalOp  = 1'b0;

    case (stateReg)
      S_IDLE: begin
        stateNext = S_FETCH;
      end

      // PC+4 computed and written while the instruction is read; IR/PC load only on the ready cycle
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = 2'b01;
        if (memReadyInt) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = S_DECODE;
        end
      end

      // Branch target is computed speculatively here and parked in ALUOut
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW:    stateNext = S_MEMADR;
          OP_RTYPE:        stateNext = S_EXEC;
          OP_BEQ, OP_BNE:  stateNext = S_BRANCH;
          OP_J:            stateNext = S_JUMP;
          OP_ADDI, OP_ANDI: stateNext = S_IMMEX;
          default: begin
            illegalOp = 1'b1;
            stateNext = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        stateNext = (opCode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReadyInt) begin
          stateNext = S_MEMWB;
        end
      end

      S_MEMWB: begin
        regWrite  = 1'b1;
        memtoReg  = 1'b1;
        instrDone = 1'b1;
        stateNext = S_FETCH;
      end

      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReadyInt) begin
          instrDone = 1'b1;
          stateNext = S_FETCH;
        end
      end

      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        stateNext = S_ALUWB;
      end

      S_ALUWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = S_FETCH;
      end

      // Datapath qualifies the PC load with the ALU zero flag
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        pcWriteBeq = (opCode == OP_BEQ);
        pcWriteBne = (opCode == OP_BNE);
        instrDone  = 1'b1;
        stateNext  = S_FETCH;
      end

      S_JUMP: begin
        pcWrite   = 1'b1;
        PCSource  = 2'b10;
        instrDone = 1'b1;
        stateNext = S_FETCH;
      end

      S_IMMEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = (opCode == OP_ANDI) ? 2'b11 : 2'b00;
        stateNext = S_IMMWB;
      end

      S_IMMWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = S_FETCH;
      end

      S_HALT: begin
        stateNext = S_HALT;
      end

      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  assign state = STATE_W'(stateReg);

endmodule
